// File: rtl/rvfi_pkg.sv
// Shared types and helpers for the RVFI retire tracker.
// XLEN/ILEN   : register/address and instruction widths
// rvfi_entry_t: one in-flight instruction (issue fields + completion fields)
// rvfi_sanitise: applies the x0 and trap zeroing rules to an outgoing packet
package rvfi_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam int unsigned MASK_W = XLEN / 8;

  typedef struct packed {
    // issue fields
    logic [ILEN-1:0]   insn;
    logic [XLEN-1:0]   pc_rdata;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    // completion fields
    logic              trap;
    logic              halt;
    logic              intr;
    logic [4:0]        rd_addr;
    logic [XLEN-1:0]   rd_wdata;
    logic [XLEN-1:0]   pc_wdata;
    logic [XLEN-1:0]   mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_entry_t;

  // x0 reads/writes report zero; a trapping instruction writes nothing.
  function automatic rvfi_entry_t rvfi_sanitise(input rvfi_entry_t e);
    rvfi_entry_t s;
    s = e;
    if (s.rs1_addr == 5'd0) s.rs1_rdata = '0;
    if (s.rs2_addr == 5'd0) s.rs2_rdata = '0;
    if (s.rd_addr == 5'd0)  s.rd_wdata  = '0;
    if (s.trap) begin
      s.rd_addr   = '0;
      s.rd_wdata  = '0;
      s.mem_wmask = '0;
    end
    return s;
  endfunction

endpackage

// File: rtl/rvfi_tag_ring.sv
// Head/tail/count bookkeeping for the in-flight ring.
// Ports: clock, reset (sync, active-low); iss_valid / ret_req requests in;
// halted blocks both sides; iss_ready, iss_fire, ret_fire, head, tail out.
module rvfi_tag_ring #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iss_valid,
  input  logic             ret_req,
  input  logic             halted,
  output logic             iss_ready,
  output logic             iss_fire,
  output logic             ret_fire,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;

  // Readiness looks only at the registered count, never at a same-cycle retire.
  assign iss_ready = (count < CNT_W'(DEPTH)) && !halted;
  assign iss_fire  = iss_valid && iss_ready;
  assign ret_fire  = ret_req && !halted;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (iss_fire) tail <= tail + TAG_W'(1);
      if (ret_fire) head <= head + TAG_W'(1);
      case ({iss_fire, ret_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rvfi_retire_tracker.sv
// In-order RVFI packet generator (NRET=1) for an out-of-order completing core.
// Ports: clock, reset (sync, active-low); iss_* issue handshake returning a
// tag; cmp_* completion by tag; rvfi_* registered trace packet; err (sticky
// protocol error); halted (a halt instruction has retired).
module rvfi_retire_tracker
  import rvfi_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = $clog2(DEPTH),
  parameter int unsigned ORDER_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  // issue
  input  logic               iss_valid,
  output logic               iss_ready,
  output logic [TAG_W-1:0]   iss_tag,
  input  logic [ILEN-1:0]    iss_insn,
  input  logic [XLEN-1:0]    iss_pc,
  input  logic [4:0]         iss_rs1_addr,
  input  logic [4:0]         iss_rs2_addr,
  input  logic [XLEN-1:0]    iss_rs1_rdata,
  input  logic [XLEN-1:0]    iss_rs2_rdata,
  // completion
  input  logic               cmp_valid,
  input  logic [TAG_W-1:0]   cmp_tag,
  input  logic               cmp_trap,
  input  logic               cmp_halt,
  input  logic               cmp_intr,
  input  logic [4:0]         cmp_rd_addr,
  input  logic [XLEN-1:0]    cmp_rd_wdata,
  input  logic [XLEN-1:0]    cmp_pc_wdata,
  input  logic [XLEN-1:0]    cmp_mem_addr,
  input  logic [XLEN-1:0]    cmp_mem_rdata,
  input  logic [XLEN-1:0]    cmp_mem_wdata,
  input  logic [MASK_W-1:0]  cmp_mem_rmask,
  input  logic [MASK_W-1:0]  cmp_mem_wmask,
  // rvfi
  output logic               rvfi_valid,
  output logic [ORDER_W-1:0] rvfi_order,
  output logic [ILEN-1:0]    rvfi_insn,
  output logic               rvfi_trap,
  output logic               rvfi_halt,
  output logic               rvfi_intr,
  output logic [4:0]         rvfi_rs1_addr,
  output logic [4:0]         rvfi_rs2_addr,
  output logic [XLEN-1:0]    rvfi_rs1_rdata,
  output logic [XLEN-1:0]    rvfi_rs2_rdata,
  output logic [4:0]         rvfi_rd_addr,
  output logic [XLEN-1:0]    rvfi_rd_wdata,
  output logic [XLEN-1:0]    rvfi_pc_rdata,
  output logic [XLEN-1:0]    rvfi_pc_wdata,
  output logic [XLEN-1:0]    rvfi_mem_addr,
  output logic [MASK_W-1:0]  rvfi_mem_rmask,
  output logic [MASK_W-1:0]  rvfi_mem_wmask,
  output logic [XLEN-1:0]    rvfi_mem_rdata,
  output logic [XLEN-1:0]    rvfi_mem_wdata,
  // status
  output logic               err,
  output logic               halted
);

  rvfi_entry_t        entries [DEPTH];
  logic [DEPTH-1:0]   alloc;
  logic [DEPTH-1:0]   done;

  logic [TAG_W-1:0]   head;
  logic [TAG_W-1:0]   tail;
  logic               iss_fire;
  logic               ret_req;
  logic               ret_fire;
  logic               cmp_ok;
  rvfi_entry_t        ret_entry;

  rvfi_entry_t        out_q;
  logic               out_valid;
  logic [ORDER_W-1:0] out_order;
  logic [ORDER_W-1:0] order_cnt;

  rvfi_tag_ring #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_ring (
    .clock     (clock),
    .reset     (reset),
    .iss_valid (iss_valid),
    .ret_req   (ret_req),
    .halted    (halted),
    .iss_ready (iss_ready),
    .iss_fire  (iss_fire),
    .ret_fire  (ret_fire),
    .head      (head),
    .tail      (tail)
  );

  assign iss_tag = tail;

  // A completion is accepted only for an allocated, not-yet-done entry that
  // is not being allocated in this very cycle.
  assign cmp_ok = cmp_valid && alloc[cmp_tag] && !done[cmp_tag]
                  && !(iss_fire && (cmp_tag == tail));

  // Head retires when done, or when its completion arrives this cycle (bypass).
  assign ret_req = alloc[head] && (done[head] || (cmp_valid && (cmp_tag == head)));

  // Outgoing packet: stored fields, with completion fields taken from the
  // completion bus when the head is being completed in this cycle.
  always_comb begin
    ret_entry = entries[head];
    if (!done[head]) begin
      ret_entry.trap      = cmp_trap;
      ret_entry.halt      = cmp_halt;
      ret_entry.intr      = cmp_intr;
      ret_entry.rd_addr   = cmp_rd_addr;
      ret_entry.rd_wdata  = cmp_rd_wdata;
      ret_entry.pc_wdata  = cmp_pc_wdata;
      ret_entry.mem_addr  = cmp_mem_addr;
      ret_entry.mem_rmask = cmp_mem_rmask;
      ret_entry.mem_wmask = cmp_mem_wmask;
      ret_entry.mem_rdata = cmp_mem_rdata;
      ret_entry.mem_wdata = cmp_mem_wdata;
    end
  end

  // Entry payload storage; validity lives in alloc/done, so no reset needed.
  always_ff @(posedge clock) begin
    if (iss_fire) begin
      entries[tail].insn      <= iss_insn;
      entries[tail].pc_rdata  <= iss_pc;
      entries[tail].rs1_addr  <= iss_rs1_addr;
      entries[tail].rs2_addr  <= iss_rs2_addr;
      entries[tail].rs1_rdata <= iss_rs1_rdata;
      entries[tail].rs2_rdata <= iss_rs2_rdata;
    end
    if (cmp_ok) begin
      entries[cmp_tag].trap      <= cmp_trap;
      entries[cmp_tag].halt      <= cmp_halt;
      entries[cmp_tag].intr      <= cmp_intr;
      entries[cmp_tag].rd_addr   <= cmp_rd_addr;
      entries[cmp_tag].rd_wdata  <= cmp_rd_wdata;
      entries[cmp_tag].pc_wdata  <= cmp_pc_wdata;
      entries[cmp_tag].mem_addr  <= cmp_mem_addr;
      entries[cmp_tag].mem_rmask <= cmp_mem_rmask;
      entries[cmp_tag].mem_wmask <= cmp_mem_wmask;
      entries[cmp_tag].mem_rdata <= cmp_mem_rdata;
      entries[cmp_tag].mem_wdata <= cmp_mem_wdata;
    end
  end

  // Entry state flags, error and halt status.
  always_ff @(posedge clock) begin
    if (!reset) begin
      alloc  <= '0;
      done   <= '0;
      err    <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (iss_fire) begin
        alloc[tail] <= 1'b1;
        done[tail]  <= 1'b0;
      end
      if (cmp_ok) done[cmp_tag] <= 1'b1;
      if (ret_fire) alloc[head] <= 1'b0;
      if (cmp_valid && !cmp_ok) err <= 1'b1;
      if (ret_fire && ret_entry.halt) halted <= 1'b1;
    end
  end

  // Output packet register; fields are zero whenever no packet is emitted.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_order <= '0;
      out_q     <= '0;
      order_cnt <= '0;
    end else begin
      out_valid <= ret_fire;
      if (ret_fire) begin
        out_q     <= rvfi_sanitise(ret_entry);
        out_order <= order_cnt;
        order_cnt <= order_cnt + ORDER_W'(1);
      end else begin
        out_q     <= '0;
        out_order <= '0;
      end
    end
  end

  assign rvfi_valid     = out_valid;
  assign rvfi_order     = out_order;
  assign rvfi_insn      = out_q.insn;
  assign rvfi_trap      = out_q.trap;
  assign rvfi_halt      = out_q.halt;
  assign rvfi_intr      = out_q.intr;
  assign rvfi_rs1_addr  = out_q.rs1_addr;
  assign rvfi_rs2_addr  = out_q.rs2_addr;
  assign rvfi_rs1_rdata = out_q.rs1_rdata;
  assign rvfi_rs2_rdata = out_q.rs2_rdata;
  assign rvfi_rd_addr   = out_q.rd_addr;
  assign rvfi_rd_wdata  = out_q.rd_wdata;
  assign rvfi_pc_rdata  = out_q.pc_rdata;
  assign rvfi_pc_wdata  = out_q.pc_wdata;
  assign rvfi_mem_addr  = out_q.mem_addr;
  assign rvfi_mem_rmask = out_q.mem_rmask;
  assign rvfi_mem_wmask = out_q.mem_wmask;
  assign rvfi_mem_rdata = out_q.mem_rdata;
  assign rvfi_mem_wdata = out_q.mem_wdata;

endmodule

// File: tb/tb_rvfi_retire_tracker.sv
// Directed self-checking bench for rvfi_retire_tracker (DEPTH=4).
module tb_rvfi_retire_tracker;

  logic        clock;
  logic        reset;
  logic        iss_valid;
  logic        iss_ready;
  logic [1:0]  iss_tag;
  logic [31:0] iss_insn;
  logic [31:0] iss_pc;
  logic [4:0]  iss_rs1_addr;
  logic [4:0]  iss_rs2_addr;
  logic [31:0] iss_rs1_rdata;
  logic [31:0] iss_rs2_rdata;
  logic        cmp_valid;
  logic [1:0]  cmp_tag;
  logic        cmp_trap;
  logic        cmp_halt;
  logic        cmp_intr;
  logic [4:0]  cmp_rd_addr;
  logic [31:0] cmp_rd_wdata;
  logic [31:0] cmp_pc_wdata;
  logic [31:0] cmp_mem_addr;
  logic [31:0] cmp_mem_rdata;
  logic [31:0] cmp_mem_wdata;
  logic [3:0]  cmp_mem_rmask;
  logic [3:0]  cmp_mem_wmask;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap;
  logic        rvfi_halt;
  logic        rvfi_intr;
  logic [4:0]  rvfi_rs1_addr;
  logic [4:0]  rvfi_rs2_addr;
  logic [31:0] rvfi_rs1_rdata;
  logic [31:0] rvfi_rs2_rdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata;
  logic [31:0] rvfi_pc_wdata;
  logic [31:0] rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask;
  logic [3:0]  rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata;
  logic [31:0] rvfi_mem_wdata;
  logic        err;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  rvfi_retire_tracker #(.DEPTH(4), .ORDER_W(64)) dut (
    .clock(clock), .reset(reset),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_tag(iss_tag),
    .iss_insn(iss_insn), .iss_pc(iss_pc),
    .iss_rs1_addr(iss_rs1_addr), .iss_rs2_addr(iss_rs2_addr),
    .iss_rs1_rdata(iss_rs1_rdata), .iss_rs2_rdata(iss_rs2_rdata),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag),
    .cmp_trap(cmp_trap), .cmp_halt(cmp_halt), .cmp_intr(cmp_intr),
    .cmp_rd_addr(cmp_rd_addr), .cmp_rd_wdata(cmp_rd_wdata),
    .cmp_pc_wdata(cmp_pc_wdata), .cmp_mem_addr(cmp_mem_addr),
    .cmp_mem_rdata(cmp_mem_rdata), .cmp_mem_wdata(cmp_mem_wdata),
    .cmp_mem_rmask(cmp_mem_rmask), .cmp_mem_wmask(cmp_mem_wmask),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
    .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata),
    .err(err), .halted(halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    iss_valid = 1'b0;
    cmp_valid = 1'b0;
  endtask

  task automatic set_iss(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                         input logic [4:0] r2, input logic [31:0] d2);
    iss_valid     = 1'b1;
    iss_pc        = pc;
    iss_insn      = pc ^ 32'h0000_0013;
    iss_rs1_addr  = r1;
    iss_rs1_rdata = d1;
    iss_rs2_addr  = r2;
    iss_rs2_rdata = d2;
  endtask

  task automatic set_cmp(input logic [1:0] tag, input logic trap, input logic halt,
                         input logic [4:0] rd, input logic [31:0] wdata,
                         input logic [3:0] wmask, input logic [3:0] rmask);
    cmp_valid     = 1'b1;
    cmp_tag       = tag;
    cmp_trap      = trap;
    cmp_halt      = halt;
    cmp_intr      = 1'b0;
    cmp_rd_addr   = rd;
    cmp_rd_wdata  = wdata;
    cmp_pc_wdata  = 32'h0000_1000;
    cmp_mem_addr  = 32'h0000_0200;
    cmp_mem_rdata = 32'h0000_0300;
    cmp_mem_wdata = 32'h0000_0400;
    cmp_mem_rmask = rmask;
    cmp_mem_wmask = wmask;
  endtask

  task automatic reset_dut();
    idle();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    set_iss(32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    set_cmp(2'd0, 1'b0, 1'b0, 5'd0, 32'h0, 4'h0, 4'h0);
    idle();
    tick();
    reset_dut();

    // reset state
    check("rst_valid", 64'(rvfi_valid), 64'd0);
    check("rst_order", rvfi_order, 64'd0);
    check("rst_ready", 64'(iss_ready), 64'd1);
    check("rst_tag", 64'(iss_tag), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // in-order issue and completion
    for (int i = 0; i < 3; i++) begin
      set_iss(32'(i * 4), 5'd1, 32'h10 + 32'(i), 5'd2, 32'h20 + 32'(i));
      check("io_tag", 64'(iss_tag), 64'(i));
      tick();
    end
    idle();
    check("io_ready", 64'(iss_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      set_cmp(2'(i), 1'b0, 1'b0, 5'd3, 32'h100 + 32'(i), 4'h0, 4'h0);
      tick();
      check("io_valid", 64'(rvfi_valid), 64'd1);
      check("io_order", rvfi_order, 64'(i));
      check("io_pc", 64'(rvfi_pc_rdata), 64'(i * 4));
      check("io_rd_wdata", 64'(rvfi_rd_wdata), 64'h100 + 64'(i));
      check("io_rs1_rdata", 64'(rvfi_rs1_rdata), 64'h10 + 64'(i));
    end
    idle();
    tick();
    check("io_idle", 64'(rvfi_valid), 64'd0);

    // out-of-order completion on a full buffer
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      set_iss(32'(i * 4), 5'd1, 32'h1, 5'd2, 32'h2);
      check("ooo_tag", 64'(iss_tag), 64'(i));
      tick();
    end
    idle();
    check("ooo_full_ready", 64'(iss_ready), 64'd0);
    for (int k = 3; k >= 1; k--) begin
      set_cmp(2'(k), 1'b0, 1'b0, 5'd4, 32'h40 + 32'(k), 4'h0, 4'h0);
      tick();
      check("ooo_hold", 64'(rvfi_valid), 64'd0);
    end
    set_cmp(2'd0, 1'b0, 1'b0, 5'd4, 32'h40, 4'h0, 4'h0);
    tick();
    idle();
    check("ooo_v0", 64'(rvfi_valid), 64'd1);
    check("ooo_o0", rvfi_order, 64'd0);
    check("ooo_ready", 64'(iss_ready), 64'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("ooo_valid", 64'(rvfi_valid), 64'd1);
      check("ooo_order", rvfi_order, 64'(i));
      check("ooo_pc", 64'(rvfi_pc_rdata), 64'(i * 4));
      check("ooo_rd_wdata", 64'(rvfi_rd_wdata), 64'h40 + 64'(i));
    end
    tick();
    check("ooo_idle", 64'(rvfi_valid), 64'd0);

    // sanitising
    reset_dut();
    set_iss(32'h40, 5'd0, 32'h1234, 5'd2, 32'h55);
    tick();
    set_iss(32'h44, 5'd1, 32'h66, 5'd0, 32'h77);
    tick();
    idle();
    set_cmp(2'd0, 1'b0, 1'b0, 5'd0, 32'hDEAD, 4'h0, 4'h0);
    tick();
    check("san_valid", 64'(rvfi_valid), 64'd1);
    check("san_rd_wdata_x0", 64'(rvfi_rd_wdata), 64'd0);
    check("san_rs1_x0", 64'(rvfi_rs1_rdata), 64'd0);
    check("san_rs2_keep", 64'(rvfi_rs2_rdata), 64'h55);
    set_cmp(2'd1, 1'b1, 1'b0, 5'd5, 32'h77, 4'hF, 4'h3);
    tick();
    idle();
    check("san_trap", 64'(rvfi_trap), 64'd1);
    check("san_wmask", 64'(rvfi_mem_wmask), 64'd0);
    check("san_rd_addr", 64'(rvfi_rd_addr), 64'd0);
    check("san_rd_wdata_trap", 64'(rvfi_rd_wdata), 64'd0);
    check("san_rmask", 64'(rvfi_mem_rmask), 64'h3);
    check("san_rs2_x0", 64'(rvfi_rs2_rdata), 64'd0);
    check("san_pc", 64'(rvfi_pc_rdata), 64'h44);

    // protocol errors
    reset_dut();
    check("err_clear", 64'(err), 64'd0);
    set_iss(32'h80, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    set_iss(32'h84, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    idle();
    set_cmp(2'd2, 1'b0, 1'b0, 5'd3, 32'h999, 4'h0, 4'h0);
    tick();
    check("err_unalloc", 64'(err), 64'd1);
    check("err_no_pkt", 64'(rvfi_valid), 64'd0);
    set_cmp(2'd1, 1'b0, 1'b0, 5'd3, 32'h111, 4'h0, 4'h0);
    tick();
    check("err_t1_hold", 64'(rvfi_valid), 64'd0);
    set_cmp(2'd1, 1'b0, 1'b0, 5'd3, 32'h222, 4'h0, 4'h0);
    tick();
    check("err_sticky", 64'(err), 64'd1);
    set_cmp(2'd0, 1'b0, 1'b0, 5'd3, 32'hAAA, 4'h0, 4'h0);
    tick();
    idle();
    check("err_v0", 64'(rvfi_valid), 64'd1);
    check("err_o0", rvfi_order, 64'd0);
    check("err_d0", 64'(rvfi_rd_wdata), 64'hAAA);
    tick();
    check("err_v1", 64'(rvfi_valid), 64'd1);
    check("err_o1", rvfi_order, 64'd1);
    check("err_first_data", 64'(rvfi_rd_wdata), 64'h111);
    check("err_still", 64'(err), 64'd1);

    // halt
    reset_dut();
    check("halt_err_rst", 64'(err), 64'd0);
    set_iss(32'hC0, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    set_iss(32'hC4, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    idle();
    set_cmp(2'd0, 1'b0, 1'b1, 5'd3, 32'h5, 4'h0, 4'h0);
    tick();
    check("halt_valid", 64'(rvfi_valid), 64'd1);
    check("halt_flag", 64'(rvfi_halt), 64'd1);
    check("halt_halted", 64'(halted), 64'd1);
    check("halt_ready", 64'(iss_ready), 64'd0);
    set_cmp(2'd1, 1'b0, 1'b0, 5'd3, 32'h6, 4'h0, 4'h0);
    tick();
    idle();
    check("halt_no_t1", 64'(rvfi_valid), 64'd0);
    tick();
    check("halt_no_t1b", 64'(rvfi_valid), 64'd0);
    check("halt_ready2", 64'(iss_ready), 64'd0);

    // reset mid-flight
    reset_dut();
    check("mid_halted_rst", 64'(halted), 64'd0);
    set_iss(32'h100, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    idle();
    set_cmp(2'd0, 1'b0, 1'b0, 5'd3, 32'h7, 4'h0, 4'h0);
    tick();
    idle();
    check("mid_pre_order", rvfi_order, 64'd0);
    for (int i = 0; i < 3; i++) begin
      set_iss(32'h104 + 32'(i * 4), 5'd1, 32'h1, 5'd2, 32'h2);
      tick();
    end
    idle();
    set_cmp(2'd2, 1'b0, 1'b0, 5'd3, 32'h8, 4'h0, 4'h0);
    tick();
    idle();
    check("mid_pending", 64'(rvfi_valid), 64'd0);
    reset_dut();
    check("mid_valid", 64'(rvfi_valid), 64'd0);
    check("mid_ready", 64'(iss_ready), 64'd1);
    check("mid_tag", 64'(iss_tag), 64'd0);
    set_iss(32'h200, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    idle();
    set_cmp(2'd0, 1'b0, 1'b0, 5'd3, 32'h9, 4'h0, 4'h0);
    tick();
    idle();
    check("mid_post_valid", 64'(rvfi_valid), 64'd1);
    check("mid_post_order", rvfi_order, 64'd0);
    check("mid_post_pc", 64'(rvfi_pc_rdata), 64'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
